// File: rtl/pipe_pkg.sv
// Shared constants and stage record for the 5-stage core's instruction pipeline registers.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam int          PC_W      = 32;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic            valid;
   } stage_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: reset > hold > bubble > load.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int          XLEN = 32,
   parameter logic [31:0] NOP  = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold,
   input  logic            bubble,
   input  logic [31:0]     d_instr,
   input  logic [XLEN-1:0] d_pc,
   input  logic            d_valid,
   output logic [31:0]     q_instr,
   output logic [XLEN-1:0] q_pc,
   output logic            q_valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_instr <= NOP;
         q_pc    <= '0;
         q_valid <= 1'b0;
      end else if (!hold) begin
         if (bubble) begin
            q_instr <= NOP;
            q_pc    <= '0;
            q_valid <= 1'b0;
         end else begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_valid <= d_valid;
         end
      end
   end

endmodule

// File: rtl/pipe_instr_regs.sv
// IF/ID -> ID/EX -> EX/MEM -> MEM/WB instruction/PC registers with stall bubbles,
// branch flush, and stall statistics / protocol checking.
module pipe_instr_regs
   import pipe_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
   parameter int          MAX_STALL = 2,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_instr,
   input  logic [XLEN-1:0]  if_pc,
   input  logic             if_valid,
   input  logic             id_stall,
   input  logic             br_flush,
   output logic             if_ready,
   output logic [31:0]      if_id_instr,
   output logic [XLEN-1:0]  if_id_pc,
   output logic             if_id_valid,
   output logic [31:0]      id_ex_instr,
   output logic [XLEN-1:0]  id_ex_pc,
   output logic             id_ex_valid,
   output logic [31:0]      ex_mem_instr,
   output logic             ex_mem_valid,
   output logic [31:0]      mem_wb_instr,
   output logic             mem_wb_valid,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             stall_err,
   output logic             proto_err
);

   localparam int NSTG  = 4;
   localparam int RUN_W = $clog2(MAX_STALL + 2);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] STALL = 1'b1;

   logic [NSTG-1:0][31:0]     d_instr, q_instr;
   logic [NSTG-1:0][XLEN-1:0] d_pc, q_pc;
   logic [NSTG-1:0]           d_vld, q_vld;
   logic [NSTG-1:0]           stg_hold, stg_bub;

   assign if_ready = ~id_stall;

   // Stage 0 is IF/ID, stage 1 ID/EX; the back end always advances.
   // IF/ID hold outranks its bubble, so a stall/flush collision keeps the stall.
   always_comb begin
      stg_hold   = {{(NSTG-1){1'b0}}, id_stall};
      stg_bub    = {{(NSTG-2){1'b0}}, id_stall, br_flush | ~if_valid};
      d_instr[0] = if_instr;
      d_pc[0]    = if_pc;
      d_vld[0]   = if_valid;
      for (int i = 1; i < NSTG; i++) begin
         d_instr[i] = q_instr[i-1];
         d_pc[i]    = q_pc[i-1];
         d_vld[i]   = q_vld[i-1];
      end
   end

   for (genvar g = 0; g < NSTG; g++) begin : g_stg
      pipe_stage_reg #(.XLEN(XLEN), .NOP(NOP_INSTR)) u_stg (
         .clk     (clk),
         .rst     (rst),
         .hold    (stg_hold[g]),
         .bubble  (stg_bub[g]),
         .d_instr (d_instr[g]),
         .d_pc    (d_pc[g]),
         .d_valid (d_vld[g]),
         .q_instr (q_instr[g]),
         .q_pc    (q_pc[g]),
         .q_valid (q_vld[g])
      );
   end

   assign if_id_instr  = q_instr[0];
   assign if_id_pc     = q_pc[0];
   assign if_id_valid  = q_vld[0];
   assign id_ex_instr  = q_instr[1];
   assign id_ex_pc     = q_pc[1];
   assign id_ex_valid  = q_vld[1];
   assign ex_mem_instr = q_instr[2];
   assign ex_mem_valid = q_vld[2];
   assign mem_wb_instr = q_instr[3];
   assign mem_wb_valid = q_vld[3];

   logic [0:0]       state;
   logic [RUN_W-1:0] run;
   logic             run_over;

   // Run length this stall cycle would reach, compared before saturation.
   assign run_over = id_stall && ((int'(run) + 1) > MAX_STALL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         run          <= '0;
         stall_cycles <= '0;
         stall_err    <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (id_stall) begin
                  state <= STALL;
                  run   <= RUN_W'(1);
               end
            end
            STALL: begin
               if (!id_stall) begin
                  state <= IDLE;
                  run   <= '0;
               end else if (run != RUN_MAX) begin
                  run <= run + RUN_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               run   <= '0;
            end
         endcase
         if (run_over)
            stall_err <= 1'b1;
         if (id_stall && br_flush)
            proto_err <= 1'b1;
         if (id_stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule
